i2c_port_arb: RTL and testbench

- Parametrised N-channel I2C-slave port arbiter. Generalises the fixed SCL/SDA, CC1/CC2 and DP/DN I2C pin routing to NCH candidate pin pairs.
- Each pair is synchronised and glitch-filtered. The arbiter locks onto the first enabled pair that shows a START condition and routes it to the single internal I2C slave until STOP, timeout or channel disable.
- Slave open-drain drive is returned only to the locked pair.

---
 rtl/i2c_port_arb.sv | 167 ++++++++++++++++
 tb/tb_i2c_port_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_port_arb.sv
// i2c_port_arb: locks one of NCH synchronised, glitch-filtered I2C pin pairs
// onto a single internal slave from START until STOP, timeout or disable.
// Ports:
//   clk, rstz          clock, async active-low reset
//   scl_i/sda_i        raw pad lines per pair
//   ch_en              per-pair enable mask
//   slv_scl_oe/sda_oe  slave pull-low requests
//   scl_o/sda_o        routed filtered lines to the slave
//   scl_oe/sda_oe      per-pair pull-low enables (locked pair only)
//   sel                one-hot locked pair, 0 when idle
//   locked             arbiter is locked
//   tout               one-cycle timeout pulse
module i2c_port_arb #(
  parameter int NCH    = 4,
  parameter int FLT    = 3,
  parameter int TOUT_W = 16
) (
  input  logic           clk,
  input  logic           rstz,
  input  logic [NCH-1:0] scl_i,
  input  logic [NCH-1:0] sda_i,
  input  logic [NCH-1:0] ch_en,
  input  logic           slv_scl_oe,
  input  logic           slv_sda_oe,
  output logic           scl_o,
  output logic           sda_o,
  output logic [NCH-1:0] scl_oe,
  output logic [NCH-1:0] sda_oe,
  output logic [NCH-1:0] sel,
  output logic           locked,
  output logic           tout
);

  localparam int NL = 2 * NCH;
  localparam int CW = (FLT > 1) ? $clog2(FLT) : 1;
  localparam logic [TOUT_W-1:0] TMAX = '1;

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  // Lines are handled as one vector: [NCH-1:0] SCL, [NL-1:NCH] SDA.
  logic [NL-1:0] s1_q;
  logic [NL-1:0] s2_q;
  logic [NL-1:0] flt_q;
  logic [NL-1:0] flt_d;
  logic [CW-1:0] cnt_q [NL];
  logic [CW-1:0] cnt_d [NL];

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      s1_q  <= '1;
      s2_q  <= '1;
      flt_q <= '1;
      for (int i = 0; i < NL; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= {sda_i, scl_i};
      s2_q  <= s1_q;
      flt_q <= flt_d;
      for (int i = 0; i < NL; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Count consecutive samples disagreeing with the filtered value;
  // the FLT-th one flips it, any agreeing sample restarts the run.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < NL; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == CW'(FLT - 1)) flt_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  logic [NCH-1:0] fscl_q, fsda_q, fscl_d, fsda_d;
  logic [NCH-1:0] start, stop, sedge, cand, win;

  assign fscl_q = flt_q[NCH-1:0];
  assign fsda_q = flt_q[NL-1:NCH];
  assign fscl_d = flt_d[NCH-1:0];
  assign fsda_d = flt_d[NL-1:NCH];

  // Events are taken on the filter update itself so a lock lands on the
  // same edge as the filtered SDA fall.
  assign start = fsda_q & ~fsda_d & fscl_q & fscl_d;
  assign stop  = ~fsda_q & fsda_d & fscl_q & fscl_d;
  assign sedge = fscl_q ^ fscl_d;
  assign cand  = start & ch_en;
  assign win   = cand & (~cand + NCH'(1));

  state_t            state_q, state_d;
  logic [NCH-1:0]    sel_q, sel_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              tout_q, tout_d;
  logic [TOUT_W-1:0] tcnt_q, tcnt_d;
  logic              en_sel, stop_sel, edge_sel;

  assign en_sel   = |(ch_en & sel_q);
  assign stop_sel = |(stop & sel_q);
  assign edge_sel = |(sedge & sel_q);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      sel_q   <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      tout_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      tout_q  <= tout_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    tout_d  = 1'b0;
    tcnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          state_d = LOCK;
          sel_d   = win;
          sda_d   = 1'b0;
        end
      end
      LOCK: begin
        scl_d = |(fscl_q & sel_q);
        sda_d = |(fsda_q & sel_q);
        if (edge_sel) tcnt_d = '0;
        else if (tcnt_q != TMAX) tcnt_d = tcnt_q + TOUT_W'(1);
        else tcnt_d = tcnt_q;
        if (!en_sel || stop_sel || tcnt_d == TMAX) begin
          state_d = IDLE;
          sel_d   = '0;
          tcnt_d  = '0;
          tout_d  = en_sel && !stop_sel;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  assign scl_o  = scl_q;
  assign sda_o  = sda_q;
  assign sel    = sel_q;
  assign locked = (state_q == LOCK);
  assign tout   = tout_q;
  assign scl_oe = sel_q & {NCH{slv_scl_oe & locked}};
  assign sda_oe = sel_q & {NCH{slv_sda_oe & locked}};

endmodule

// File: tb/tb_i2c_port_arb.sv
// tb_i2c_port_arb: directed bench for i2c_port_arb
// (NCH=4, FLT=3, TOUT_W=4).
module tb_i2c_port_arb;

  logic       clk = 1'b0;
  logic       rstz;
  logic [3:0] scl_i, sda_i, ch_en;
  logic       slv_scl_oe, slv_sda_oe;
  logic       scl_o, sda_o, locked, tout;
  logic [3:0] scl_oe, sda_oe, sel;

  int total = 0;
  int bad   = 0;

  i2c_port_arb #(.NCH(4), .FLT(3), .TOUT_W(4)) dut (
    .clk        (clk),
    .rstz       (rstz),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .ch_en      (ch_en),
    .slv_scl_oe (slv_scl_oe),
    .slv_sda_oe (slv_sda_oe),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sel        (sel),
    .locked     (locked),
    .tout       (tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [3:0] st;
    logic [3:0] sel;
    logic       lk;
  } vec_t;

  vec_t tv[8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic to_idle();
    ch_en = 4'b0000;
    step(1);
    sda_i = 4'hf;
    scl_i = 4'hf;
    step(8);
    ch_en = 4'b1111;
    step(1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".scl_o"}, scl_o, 1);
    chk({nm, ".sda_o"}, sda_o, 1);
    chk({nm, ".scl_oe"}, scl_oe, 0);
    chk({nm, ".sda_oe"}, sda_oe, 0);
    chk({nm, ".sel"}, sel, 0);
    chk({nm, ".locked"}, locked, 0);
    chk({nm, ".tout"}, tout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] byte_v;
    logic [7:0] got;

    tv[0] = '{4'b1111, 4'b0100, 4'b0100, 1'b1};
    tv[1] = '{4'b1111, 4'b1010, 4'b0010, 1'b1};
    tv[2] = '{4'b1011, 4'b0100, 4'b0000, 1'b0};
    tv[3] = '{4'b1111, 4'b0001, 4'b0001, 1'b1};
    tv[4] = '{4'b0110, 4'b1111, 4'b0010, 1'b1};
    tv[5] = '{4'b1000, 4'b0111, 4'b0000, 1'b0};
    tv[6] = '{4'b0000, 4'b1111, 4'b0000, 1'b0};
    tv[7] = '{4'b1100, 4'b1100, 4'b0100, 1'b1};

    rstz = 1'b0;
    scl_i = 4'hf;
    sda_i = 4'hf;
    ch_en = 4'b1111;
    slv_scl_oe = 1'b0;
    slv_sda_oe = 1'b0;
    step(3);
    chk_reset("rst");
    rstz = 1'b1;
    step(8);
    chk_reset("idle");

    // table: START patterns against enable masks
    for (int i = 0; i < 8; i++) begin
      ch_en = tv[i].en;
      step(1);
      sda_i = ~tv[i].st;
      step(4);
      chk($sformatf("tv%0d.early", i), locked, 0);
      step(1);
      chk($sformatf("tv%0d.sel", i), sel, tv[i].sel);
      chk($sformatf("tv%0d.lk", i), locked, tv[i].lk);
      to_idle();
    end

    // START on pair 2, byte 0xA5, STOP
    sda_i[2] = 1'b0;
    step(5);
    chk("b.sel", sel, 4'b0100);
    step(1);
    chk("b.scl0", scl_o, 1);
    chk("b.sda0", sda_o, 0);
    byte_v = 8'hA5;
    got = '0;
    for (int b = 7; b >= 0; b--) begin
      scl_i[2] = 1'b0;
      step(4);
      sda_i[2] = byte_v[b];
      step(4);
      scl_i[2] = 1'b1;
      step(8);
      got = {got[6:0], sda_o};
    end
    chk("b.byte", got, 8'hA5);
    chk("b.lk", locked, 1);
    scl_i[2] = 1'b0;
    step(4);
    sda_i[2] = 1'b0;
    step(4);
    scl_i[2] = 1'b1;
    step(8);
    sda_i[2] = 1'b1;
    step(4);
    chk("b.prestop", locked, 1);
    step(1);
    chk("b.stop.lk", locked, 0);
    chk("b.stop.sel", sel, 0);
    step(1);
    chk("b.stop.scl", scl_o, 1);
    chk("b.stop.sda", sda_o, 1);
    to_idle();

    // simultaneous STARTs then a START on pair 0 while locked
    sda_i = 4'b0101;
    step(5);
    chk("c.sel", sel, 4'b0010);
    sda_i[0] = 1'b0;
    step(6);
    chk("c.keep", sel, 4'b0010);
    chk("c.lk", locked, 1);
    to_idle();

    // return path on pair 0
    sda_i[0] = 1'b0;
    step(5);
    slv_sda_oe = 1'b1;
    #1;
    chk("d.sda_oe", sda_oe, 4'b0001);
    chk("d.scl_oe0", scl_oe, 4'b0000);
    slv_scl_oe = 1'b1;
    #1;
    chk("d.scl_oe", scl_oe, 4'b0001);
    slv_scl_oe = 1'b0;
    sda_i[0] = 1'b1;
    step(5);
    chk("d.stop.lk", locked, 0);
    chk("d.stop.oe", sda_oe, 4'b0000);
    slv_sda_oe = 1'b0;
    to_idle();

    // timeout on pair 1
    sda_i[1] = 1'b0;
    step(5);
    chk("e.lk", locked, 1);
    scl_i[1] = 1'b0;
    step(19);
    chk("e.pre.lk", locked, 1);
    chk("e.pre.to", tout, 0);
    step(1);
    chk("e.lk0", locked, 0);
    chk("e.to", tout, 1);
    step(1);
    chk("e.to1", tout, 0);
    to_idle();

    // timeout coinciding with disable: disable wins, no pulse
    sda_i[1] = 1'b0;
    step(5);
    scl_i[1] = 1'b0;
    step(19);
    ch_en = 4'b1101;
    step(1);
    chk("f.lk", locked, 0);
    chk("f.to", tout, 0);
    step(1);
    chk("f.to1", tout, 0);
    to_idle();

    // glitch filtering on pair 0
    sda_i[0] = 1'b0;
    step(2);
    sda_i[0] = 1'b1;
    step(8);
    chk("g.glitch2", locked, 0);
    sda_i[0] = 1'b0;
    step(3);
    sda_i[0] = 1'b1;
    step(2);
    chk("g.glitch3.lk", locked, 1);
    chk("g.glitch3.sel", sel, 4'b0001);
    to_idle();

    // async reset in the middle of a lock
    sda_i[0] = 1'b0;
    step(5);
    slv_sda_oe = 1'b1;
    step(1);
    chk("h.lk", locked, 1);
    chk("h.sda", sda_o, 0);
    rstz = 1'b0;
    #1;
    chk_reset("h.rst");
    step(2);
    rstz = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
